// File: rtl/mul_div_sequencer_if.sv
// Handshake and kernel-control bundle between the multiply/divide sequencer
// and the surrounding datapath/kernel logic.
interface mul_div_sequencer_if #(
    parameter int PARALLELISM = 32
);
    logic                   start;
    logic [2:0]             opCode;
    logic [PARALLELISM-1:0] multiplierIn;
    logic                   signSel;
    logic                   non0;
    logic [2:0]             opCodeOut;
    logic [1:0]             multDecisionBits;
    logic                   saveReminder;
    logic                   loadOperands;
    logic                   iterEnable;
    logic                   busy;
    logic                   done;
    logic [PARALLELISM-1:0] quotient;

    modport master (
        output start, opCode, multiplierIn, signSel, non0,
        input  opCodeOut, multDecisionBits, saveReminder, loadOperands,
               iterEnable, busy, done, quotient
    );

    modport slave (
        input  start, opCode, multiplierIn, signSel, non0,
        output opCodeOut, multDecisionBits, saveReminder, loadOperands,
               iterEnable, busy, done, quotient
    );
endinterface

// File: rtl/mul_div_sequencer.sv
// Control sequencer for a shared iterative multiply/divide datapath: schedules
// LOAD/ITERATE/SAVE_REM/DONE, recodes Booth pairs and converts signed-digit quotients.
module mul_div_sequencer #(
    parameter int PARALLELISM = 32,
    parameter int ITERATIONS  = PARALLELISM + 1
) (
    input  logic               clk,
    input  logic               rst,
    mul_div_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(ITERATIONS + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        ITERATE  = 3'd2,
        SAVE_REM = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                 stateR;
    state_t                 nextStateS;
    logic [PARALLELISM:0]   mqR;
    logic                   mqPrevR;
    logic [PARALLELISM:0]   qPosR;
    logic [PARALLELISM:0]   qNegR;
    logic [CNT_W-1:0]       counterR;
    logic [2:0]             opCodeR;
    logic [PARALLELISM-1:0] quotientR;
    logic [PARALLELISM-1:0] qDiffS;
    logic                   isDivS;

    assign isDivS = opCodeR[2];
    // Only the low word of the modular difference is kept as the quotient
    assign qDiffS = PARALLELISM'(qPosR - qNegR);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR <= IDLE;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Next-state decode
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            IDLE: begin
                if (bus.start) nextStateS = LOAD;
                else           nextStateS = IDLE;
            end
            LOAD:    nextStateS = ITERATE;
            ITERATE: begin
                if (counterR == LAST_ITER) nextStateS = SAVE_REM;
                else                       nextStateS = ITERATE;
            end
            SAVE_REM: nextStateS = DONE;
            DONE:     nextStateS = IDLE;
            default:  nextStateS = IDLE;
        endcase
    end

    // Operand, digit-accumulator, counter and quotient registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mqR       <= '0;
            mqPrevR   <= 1'b0;
            qPosR     <= '0;
            qNegR     <= '0;
            counterR  <= '0;
            opCodeR   <= 3'b000;
            quotientR <= '0;
        end else begin
            case (stateR)
                IDLE: begin
                    if (bus.start) begin
                        opCodeR  <= bus.opCode;
                        mqR      <= bus.opCode[0] ? {1'b0, bus.multiplierIn}
                                                  : {bus.multiplierIn[PARALLELISM-1], bus.multiplierIn};
                        mqPrevR  <= 1'b0;
                        qPosR    <= '0;
                        qNegR    <= '0;
                        counterR <= '0;
                    end
                end
                LOAD: quotientR <= '0;
                ITERATE: begin
                    counterR <= counterR + CNT_W'(1);
                    if (isDivS) begin
                        qPosR <= {qPosR[PARALLELISM-1:0], bus.non0 & ~bus.signSel};
                        qNegR <= {qNegR[PARALLELISM-1:0], bus.non0 & bus.signSel};
                    end else begin
                        mqPrevR <= mqR[0];
                        mqR     <= {mqR[PARALLELISM], mqR[PARALLELISM:1]};
                    end
                end
                SAVE_REM: begin
                    if (isDivS) quotientR <= qDiffS;
                end
                default: ;
            endcase
        end
    end

    // Strobes and Booth pair decoded from the state register alone
    always_comb begin
        bus.loadOperands     = 1'b0;
        bus.iterEnable       = 1'b0;
        bus.saveReminder     = 1'b0;
        bus.done             = 1'b0;
        bus.multDecisionBits = 2'b00;
        case (stateR)
            LOAD:    bus.loadOperands = 1'b1;
            ITERATE: begin
                bus.iterEnable = 1'b1;
                if (!isDivS) bus.multDecisionBits = {mqR[0], mqPrevR};
                else         bus.multDecisionBits = 2'b00;
            end
            SAVE_REM: bus.saveReminder = 1'b1;
            DONE:     bus.done         = 1'b1;
            default:  ;
        endcase
    end

    assign bus.busy      = (stateR != IDLE);
    assign bus.opCodeOut = opCodeR;
    assign bus.quotient  = quotientR;
endmodule

// File: doc/mul_div_sequencer.md
MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 The block SHALL have parameter PARALLELISM, default 32, giving the operand width in bits.
REQ-002 The block SHALL have parameter ITERATIONS, default PARALLELISM+1, giving the number of kernel iterations per operation.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin an operation; it is sampled only in IDLE.
REQ-006 The block SHALL have port opCode, input, 3 bits: bit2 selects division (1) or multiplication (0); bit0 selects unsigned (1) or signed (0).
REQ-007 The block SHALL have port multiplierIn, input, PARALLELISM bits: the multiplier operand, used when opCode[2]=0.
REQ-008 The block SHALL have port signSel, input, 1 bit: the quotient-digit sign returned by the kernel logic.
REQ-009 The block SHALL have port non0, input, 1 bit: the quotient-digit non-zero flag returned by the kernel logic.
REQ-010 The block SHALL have port opCodeOut, output, 3 bits: the latched opCode, driven to the kernel logic.
REQ-011 The block SHALL have port multDecisionBits, output, 2 bits: the radix-2 Booth pair driven to the kernel logic.
REQ-012 The block SHALL have port saveReminder, output, 1 bit: high during the remainder-save state.
REQ-013 The block SHALL have port loadOperands, output, 1 bit: operand-register load strobe for the datapath.
REQ-014 The block SHALL have port iterEnable, output, 1 bit: shift/accumulate enable for the datapath, high in every iteration cycle.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-017 The block SHALL have port quotient, output, PARALLELISM bits: the converted quotient, valid from done onward.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, LOAD, ITERATE, SAVE_REM and DONE.
REQ-019 In IDLE, start=1 SHALL cause a transition to LOAD and SHALL latch opCode into opCodeOut.
REQ-020 On the same start edge, the block SHALL load register mq (PARALLELISM+1 bits) with multiplierIn, sign-extended when opCode[0]=0 and zero-extended when opCode[0]=1.
REQ-021 On the same start edge, the block SHALL clear mqPrev, qPos, qNeg and the iteration counter.
REQ-022 LOAD SHALL last 1 cycle with loadOperands=1, then transition to ITERATE.
REQ-023 ITERATE SHALL last exactly ITERATIONS cycles with iterEnable=1; the counter SHALL be $clog2(ITERATIONS+1) bits wide, and the state SHALL exit to SAVE_REM when counter==ITERATIONS-1.
REQ-024 For multiplication, multDecisionBits SHALL equal {mq[0], mqPrev} combinationally during ITERATE and 2'b00 in all other states.
REQ-025 For multiplication, each ITERATE edge SHALL set mqPrev<=mq[0] and arithmetic-shift mq right by 1.
REQ-026 For division, each ITERATE edge SHALL set qPos<={qPos,(non0&~signSel)} and qNeg<={qNeg,(non0&signSel)}, both PARALLELISM+1 bits with the MSB discarded on shift.
REQ-027 For division, multDecisionBits SHALL be 2'b00.
REQ-028 SAVE_REM SHALL last 1 cycle with saveReminder=1, and SHALL register quotient <= (qPos-qNeg)[PARALLELISM-1:0] modulo 2^(PARALLELISM+1).
REQ-029 For multiplication, SAVE_REM SHALL leave quotient at 0.
REQ-030 DONE SHALL last 1 cycle with done=1, then transition to IDLE.
REQ-031 quotient SHALL hold its value until the next operation's LOAD clears it.
REQ-032 Latency SHALL be ITERATIONS+3 cycles: with start sampled at edge 0, done SHALL be high in the cycle following edge ITERATIONS+2 (edge 35 for the defaults).
REQ-033 start SHALL be ignored in every state except IDLE, including DONE, so there is no same-cycle restart.
REQ-034 opCode and multiplierIn SHALL be ignored outside the IDLE start edge.
REQ-035 loadOperands, iterEnable, saveReminder and done SHALL be mutually exclusive, each decoded from the state alone.

Reset
REQ-036 rst=1 SHALL asynchronously force IDLE from any state, including mid-ITERATE.
REQ-037 rst=1 SHALL clear mq, mqPrev, qPos, qNeg, the counter, opCodeOut and quotient to 0.
REQ-038 While rst=1, busy, done, saveReminder, loadOperands, iterEnable and multDecisionBits SHALL be 0.
REQ-039 After rst deasserts, the first start SHALL behave exactly as one issued after a normal completion.

Verification
REQ-040 The bench SHALL cover reset: assert rst asynchronously between edges -> all outputs 0 immediately, busy=0.
REQ-041 The bench SHALL cover multiplication: opCode=3'b000, multiplierIn=32'h0000_0005, start -> multDecisionBits over ITERATE cycles 1-4 is 10, 01, 10, 01, then 00 for the remaining 29 cycles; done one cycle after edge 35; quotient=0.
REQ-042 The bench SHALL cover division: opCode=3'b100, digits 0 for cycles 1-31, then +1 (non0=1, signSel=0), then -1 (non0=1, signSel=1) -> qPos=2, qNeg=1, quotient=32'h0000_0001 at done.
REQ-043 The bench SHALL cover an all-positive digit stream: opCode=3'b101, non0=1 and signSel=0 for all 33 cycles -> quotient=32'hFFFF_FFFF.
REQ-044 The bench SHALL cover ignored start: pulse start at ITERATE cycle 10 and during DONE -> no restart, done pulses once, busy falls one cycle after done.
REQ-045 The bench SHALL cover reset mid-operation: rst during ITERATE cycle 20, then start a new multiplication -> busy=0 at once, quotient=0, and the next operation completes with normal latency.
